// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, the IF/ID entry type and
// the reset fetch address.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        FULL,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register that absorbs a fetched word while
// the IF/ID register is stalled.
module fetch_skid_buffer
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic         clr,
    input  fetch_entry_t wr_entry,
    output logic         valid,
    output fetch_entry_t entry
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clr) begin
            valid_d = 1'b0;
        end
        if (wr_en) begin
            valid_d = 1'b1;
            entry_d = wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid = valid_q;
    assign entry = entry_q;

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: PC, imem req/ack, skid buffer and IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to keep the sequential word after a redirect.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_if.master      imem,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        instruction,
    output logic [31:0]        instr_pc,
    output logic               instr_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         valid_q, valid_d;
    logic         req_q, req_d;

    logic         ack, redirect, out_free;
    logic [31:0]  target, next_seq;
    logic         skid_wr, skid_clr, skid_valid;
    fetch_entry_t skid_entry, fetched;

`ifdef BRANCH_DELAY_SLOT_EN
    logic         pend_q, pend_d;
    logic [31:0]  tgt_q, tgt_d;
    assign next_seq = pend_q ? tgt_q : pc_q + 32'd4;
`else
    assign next_seq = pc_q + 32'd4;
`endif

    assign ack      = imem.imem_ack & req_q;
    assign redirect = redirect_valid & ~stall;
    assign target   = word_align(redirect_pc);
    assign out_free = ~valid_q | ~stall;
    assign fetched  = '{instr: imem.imem_rdata, pc: addr_q};

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (skid_wr),
        .clr      (skid_clr),
        .wr_entry (fetched),
        .valid    (skid_valid),
        .entry    (skid_entry)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        req_d    = req_q;
        skid_wr  = 1'b0;
        skid_clr = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_d   = pend_q;
        tgt_d    = tgt_q;
`endif
        case (state_q)
            FETCH: begin
                req_d = 1'b1;
                if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    // The in-flight sequential word is the delay slot: keep it and
                    // park the target until its ack if it has not returned yet.
                    if (ack) begin
                        instr_d = fetched.instr;
                        ipc_d   = fetched.pc;
                        valid_d = 1'b1;
                        pc_d    = target;
                        addr_d  = target;
                        pend_d  = 1'b0;
                    end else if (req_q) begin
                        valid_d = 1'b0;
                        pend_d  = 1'b1;
                        tgt_d   = target;
                    end else begin
                        valid_d = 1'b0;
                        pc_d    = target;
                        addr_d  = target;
                    end
`else
                    valid_d = 1'b0;
                    pc_d    = target;
                    if (req_q && !imem.imem_ack) begin
                        state_d = DROP;
                    end else begin
                        addr_d = target;
                    end
`endif
                end else if (ack) begin
                    pc_d   = next_seq;
                    addr_d = next_seq;
`ifdef BRANCH_DELAY_SLOT_EN
                    pend_d = 1'b0;
`endif
                    if (out_free) begin
                        instr_d = fetched.instr;
                        ipc_d   = fetched.pc;
                        valid_d = 1'b1;
                    end else begin
                        skid_wr = 1'b1;
                        state_d = FULL;
                        req_d   = 1'b0;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            FULL: begin
                if (redirect || !stall) begin
                    skid_clr = 1'b1;
                    state_d  = FETCH;
                    req_d    = 1'b1;
                    instr_d  = skid_entry.instr;
                    ipc_d    = skid_entry.pc;
                    valid_d  = 1'b1;
                end
                if (redirect) begin
                    pc_d   = target;
                    addr_d = target;
`ifndef BRANCH_DELAY_SLOT_EN
                    valid_d = 1'b0;
`endif
                end
            end
            DROP: begin
                valid_d = 1'b0;
                if (redirect) begin
                    pc_d = target;
                end
                if (ack) begin
                    state_d = FETCH;
                    addr_d  = redirect ? target : pc_q;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q  <= 1'b0;
            tgt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            req_q   <= req_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
`endif
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instruction    = instr_q;
    assign instr_pc       = ipc_q;
    assign instr_valid    = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a latency-programmable memory model feeds
// the fetch stage and every consumed IF/ID word is matched against a queue.
module tb_instr_fetch;
    import mips_pkg::*;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit BDS = 1'b1;
`else
    localparam bit BDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    instr_fetch_if imem_bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem_bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    bit          mon_en = 1'b0;
    int unsigned lat = 0;
    int unsigned mem_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    // Memory: acks a held request after `lat` wait cycles.
    always @(negedge clk) begin
        if (reset || !imem_bus.imem_req) begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = 32'hBADB_AD00;
            mem_cnt = 0;
        end else if (mem_cnt >= lat) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
            mem_cnt = 0;
        end else begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = 32'hBADB_AD00;
            mem_cnt++;
        end
    end

    // Each cycle the decoder consumes a word, it must be the next expected one.
    always @(negedge clk) begin
        if (mon_en && !reset && instr_valid && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra got pc=%h instr=%h, none required", instr_pc, instruction);
            end else begin
                mon_exp = exp_q.pop_front();
                if (instr_pc !== mon_exp || instruction !== mem_word(mon_exp)) begin
                    errors++;
                    $display("FAIL scoreboard got pc=%h instr=%h required pc=%h instr=%h",
                             instr_pc, instruction, mon_exp, mem_word(mon_exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned l);
        mon_en = 1'b0;
        exp_q.delete();
        lat = l;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        stall = 1'b1;
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b required 0", imem_bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", instr_valid); end
        checks++; if (instruction !== NOP_INSTR) begin errors++; $display("FAIL rst_instr got %h required %h", instruction, NOP_INSTR); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h required 0", instr_pc); end
        checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h required 0", imem_bus.imem_addr); end
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got req=%b addr=%h required req=1 addr=0", imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        bit ok;
        do_reset(0);
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        mon_en = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %b required 0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL stream_c2 got valid=%b pc=%h required valid=1 pc=0", instr_valid, instr_pc);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_rate got valid=%b pc=%h required valid=1 pc=%h", instr_valid, instr_pc, 32'(4 * k));
            end
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stream_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset(0);
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(4 * k));
        mon_en = 1'b1;
        repeat (3) tick();
        stall = 1'b1;
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL stall_pre got pc=%h required 4", instr_pc); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instr_pc !== 32'h4 || instruction !== mem_word(32'h4) || instr_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold got pc=%h instr=%h valid=%b required pc=4 instr=%h valid=1",
                                   instr_pc, instruction, instr_valid, mem_word(32'h4));
            end
            checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req got %b required 0", imem_bus.imem_req); end
        end
        tick();
        stall = 1'b0;
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL stall_release got pc=%h required 4", instr_pc); end
        tick();
        checks++; if (instr_pc !== 32'h8 || imem_bus.imem_addr !== 32'hC) begin
            errors++; $display("FAIL skid_out got pc=%h addr=%h required pc=8 addr=c", instr_pc, imem_bus.imem_addr);
        end
        tick();
        checks++; if (instr_pc !== 32'hC) begin errors++; $display("FAIL after_skid got pc=%h required c", instr_pc); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        bit ok;
        do_reset(2);
        exp_q.push_back(32'h0);
        if (BDS) exp_q.push_back(32'h4);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        mon_en = 1'b1;
        repeat (4) tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL redir_pre got valid=%b pc=%h required valid=1 pc=0", instr_valid, instr_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL redir_c1 got req=%b addr=%h valid=%b required req=1 addr=4 valid=0",
                               imem_bus.imem_req, imem_bus.imem_addr, instr_valid);
        end
        tick();
        checks++; if (imem_bus.imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL redir_stale got addr=%h valid=%b required addr=4 valid=0", imem_bus.imem_addr, instr_valid);
        end
        tick();
        checks++; if (imem_bus.imem_addr !== 32'h100 || instr_valid !== BDS) begin
            errors++; $display("FAIL redir_target got addr=%h valid=%b required addr=100 valid=%b", imem_bus.imem_addr, instr_valid, BDS);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got valid=%b required 0", instr_valid); end
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            errors++; $display("FAIL redir_arrive got valid=%b pc=%h required valid=1 pc=100", instr_valid, instr_pc);
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL redir_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_delay_slot();
        bit ok;
        bit found;
        do_reset(0);
        for (int k = 0; k <= 16; k++) exp_q.push_back(32'(4 * k));
        if (BDS) exp_q.push_back(32'h44);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        mon_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_valid && instr_pc == 32'h40) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL branch_reach got pc=%h required 40", instr_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== BDS || imem_bus.imem_addr !== 32'h200) begin
            errors++; $display("FAIL slot got valid=%b addr=%h required valid=%b addr=200", instr_valid, imem_bus.imem_addr, BDS);
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
            errors++; $display("FAIL branch_target got valid=%b pc=%h required valid=1 pc=200", instr_valid, instr_pc);
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL branch_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset(0);
        exp_q.push_back(32'h0);
        if (BDS) exp_q.push_back(32'h4);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        mon_en = 1'b1;
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFB;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_align got %h required fffffff8", imem_bus.imem_addr); end
        tick();
        checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_last got %h required fffffffc", imem_bus.imem_addr); end
        tick();
        checks++; if (imem_bus.imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr got addr=%h pc=%h required addr=0 pc=fffffffc", imem_bus.imem_addr, instr_pc);
        end
        tick();
        checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_out got pc=%h valid=%b required pc=0 valid=1", instr_pc, instr_valid);
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset(3);
        stall = 1'b1;
        repeat (5) tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL mid_pre got valid=%b pc=%h required valid=1 pc=0", instr_valid, instr_pc);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== NOP_INSTR
                      || instr_pc !== 32'h0 || imem_bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL mid_reset got req=%b valid=%b instr=%h pc=%h addr=%h required all 0",
                               imem_bus.imem_req, instr_valid, instruction, instr_pc, imem_bus.imem_addr);
        end
        reset = 1'b0;
        stall = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        mon_en = 1'b1;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL mid_restart got req=%b addr=%h required req=1 addr=0", imem_bus.imem_req, imem_bus.imem_addr);
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_drain got %0d left required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_delay_slot();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the MIPS core, directly upstream of the instruction decoder/controller. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and holds the fetched word plus its PC in the IF/ID output register that the controller decodes. It absorbs downstream stalls through a one-entry skid buffer and applies PC redirects (branch, jump, jr) supplied by the decode/execute logic.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  word address of the request; stable while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  instruction word; valid only with imem_ack.
- stall  in  1  downstream cannot accept a new instruction; output register holds.
- redirect_valid  in  1  one-cycle pulse: change fetch stream to redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 00.
- instruction  out  32  IF/ID instruction word for the controller.
- instr_pc  out  32  address of instruction.
- instr_valid  out  1  instruction/instr_pc hold a live instruction.

## Operation
- Reset values: pc=RESET_PC, instruction=32'h0000_0000 (NOP), instr_pc=0, instr_valid=0, imem_req=0, skid empty, state FETCH.
- States: FETCH (imem_req=1, imem_addr=pc); FULL (skid occupied, imem_req=0); DROP (imem_req=1 on a stale address, returned word discarded).
- FETCH, imem_ack=1: if output free (instr_valid=0 or stall=0), load output with {imem_rdata, pc}, instr_valid=1; else write skid, go FULL. pc<=pc+4 either way.
- FETCH, output consumed (stall=0) with no ack and no skid data: instr_valid<=0 next cycle.
- FULL: when stall=0, skid moves to output, skid empties, go FETCH.
- Redirect (legal only when stall=0; redirect with stall=1 is ignored): pc<=redirect_pc&~3; instr_valid<=0, skid cleared. If a request is outstanding without ack this cycle, go DROP; an ack in the redirect cycle is discarded.
- DROP: on imem_ack discard data, go FETCH at pc.
- Address arithmetic modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
- Simultaneous redirect and ack: redirect wins. Simultaneous reset and anything: reset wins; outstanding request abandoned (memory is reset on the same reset).

## Timing
- imem_req high in first cycle after reset deasserts.
- Zero-wait memory (ack same cycle as req): instruction valid the cycle after ack; sustained throughput 1 instruction/cycle with stall=0.
- Redirect-to-target latency: target word on output 1 cycle after its ack; bubble count = cycles until target ack + 1.
- stall=1 keeps instruction, instr_pc, instr_valid bit-stable.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: on redirect, the sequential word at (redirecting instr_pc)+4 is kept, whether in skid, acked in the redirect cycle, or still outstanding (delivered on its ack, no DROP); fetch then resumes at redirect_pc, held in a pending-target register.
- Undefined: all sequential words after the redirecting instruction are discarded as in Operation.

## Structure
- Shared package mips_pkg: NOP_INSTR=32'h0000_0000, default RESET_PC, fetch state enum {FETCH, FULL, DROP}.
- One sub-module: fetch_skid_buffer (one-entry {instr, pc} holding register with valid flag).

## Test plan
- Reset release, ack same cycle as req, RESET_PC=0 -> instr_pc 0,4,8,… on consecutive cycles, instr_valid=1 from cycle 2.
- stall=1 for 3 cycles while ack arrives -> output unchanged, skid captures pc+4 word, imem_req=0 in FULL; stall release delivers skid word, no word lost or duplicated.
- redirect_valid with redirect_pc=32'h0000_0103 while request outstanding -> next ack discarded, fetch address 32'h0000_0100, instr_valid=0 until it returns.
- BRANCH_DELAY_SLOT_EN: branch at 0x40 redirects to 0x200 -> output sequence 0x40, 0x44, 0x200.
- pc=32'hFFFF_FFFC fetched -> next imem_addr 32'h0000_0000.
- reset asserted mid-request with 3-cycle memory latency -> next cycle all outputs at reset values, fetch restarts at RESET_PC.
